// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, the byte lane mask and the lane helpers.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] BYTE_MASK = 32'hFF;
  localparam int          CNT_W     = 16;

  // Zero-extended byte from lane `lane` of `word`.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane);
    return (word >> {lane, 3'b000}) & BYTE_MASK;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Word-organised data RAM: synchronous writes with four byte-enable lanes,
// combinational read. Contents are never cleared by reset.
module dmem_bram #(
  parameter int ADR_W = 6
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [ADR_W-1:0] adr,
  input  logic [31:0]      wdat,
  output logic [31:0]      rdat
);

  logic [31:0] mem [2**ADR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[adr][i*8 +: 8] <= wdat[i*8 +: 8];
    end
  end

  assign rdat = mem[adr];

endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder: request/response handshake in front of
// the data RAM with fixed latency, byte lanes, range error and stall output.
//
// Handshake: a request transfers at a rising edge where req_val && req_rdy,
// a response transfers at a rising edge where resp_val && resp_rdy; resp_rdat
// and resp_err are held stable while resp_val waits for resp_rdy.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int ADR_W = 6,
  parameter int LAT   = 2
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [31:0]       req_adr,
  input  logic [31:0]       req_wdat,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [31:0]       resp_rdat,
  output logic              resp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  busy_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q, byte_q;
  logic [31:0] adr_q, wdat_q;

  logic        accept, commit, adr_err;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdat, ram_rdat, load_dat;

  assign accept  = (state == IDLE) && req_val;
  assign commit  = (state == ACCESS) && (cnt == 4'd0);
  assign adr_err = |adr_q[31:ADR_W+2];

  // The flush term keeps a store landing on a reset edge from touching RAM.
  assign ram_we   = (commit && we_q && !adr_err && flush)
                    ? (byte_q ? lane_enable(adr_q[1:0]) : 4'hF) : 4'h0;
  assign ram_wdat = byte_q ? {4{wdat_q[7:0]}} : wdat_q;
  assign load_dat = adr_err ? 32'd0
                  : (byte_q ? lane_extract(ram_rdat, adr_q[1:0]) : ram_rdat);

  dmem_bram #(.ADR_W(ADR_W)) u_bram (
    .clk  (clk),
    .we   (ram_we),
    .adr  (adr_q[ADR_W+1:2]),
    .wdat (ram_wdat),
    .rdat (ram_rdat)
  );

  always_ff @(posedge clk) begin
    if (!flush) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_val)  state_nxt = ACCESS;
      ACCESS:  if (commit)   state_nxt = RESP;
      RESP:    if (resp_rdy) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE:    begin req_rdy = 1'b1; busy = 1'b0; end
      RESP:    resp_val = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!flush) begin
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      adr_q     <= 32'd0;
      wdat_q    <= 32'd0;
      resp_rdat <= 32'd0;
      resp_err  <= 1'b0;
      acc_cnt   <= '0;
      busy_cnt  <= '0;
    end else begin
      if (accept) begin
        we_q   <= req_we;
        byte_q <= req_byte;
        adr_q  <= req_adr;
        wdat_q <= req_wdat;
        cnt    <= CNT_INIT;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        resp_rdat <= we_q ? 32'd0 : load_dat;
        resp_err  <= adr_err;
      end
      if (resp_val && resp_rdy) acc_cnt <= acc_cnt + 1'b1;
      if (busy) busy_cnt <= busy_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed plus lightly randomised bench for dmem_resp: expected responses are
// queued at request time and compared when the response handshake occurs.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int ADR_W = 6;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        flush;
  logic        req_val, req_rdy, req_we, req_byte;
  logic [31:0] req_adr, req_wdat;
  logic        resp_val, resp_rdy, resp_err, busy;
  logic [31:0] resp_rdat;
  logic [15:0] acc_cnt, busy_cnt;
  logic [1:0]  dbg_state;

  int          checks   = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];
  logic [15:0] exp_acc  = 16'd0;
  logic [15:0] exp_busy = 16'd0;

  dmem_resp #(.ADR_W(ADR_W), .LAT(LAT)) dut (
    .clk       (clk),
    .flush     (flush),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_adr   (req_adr),
    .req_wdat  (req_wdat),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_rdat (resp_rdat),
    .resp_err  (resp_err),
    .busy      (busy),
    .acc_cnt   (acc_cnt),
    .busy_cnt  (busy_cnt),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      $error("check %s mismatched", tag);
    end
  endtask

  // One full request/response; stall = cycles resp_rdy is held low in RESP.
  task automatic transact(input logic we, input logic bt, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic [31:0] exp_rdat,
                          input logic exp_err, input int stall, input string tag);
    int          lat;
    logic [32:0] expv;
    @(negedge clk);
    for (int n = 0; n < 20 && !req_rdy; n++) @(negedge clk);
    chk({tag, "_req_rdy"}, 32'(req_rdy), 32'd1);
    req_val  = 1'b1;
    req_we   = we;
    req_byte = bt;
    req_adr  = adr;
    req_wdat = wdat;
    exp_q.push_back({exp_err, exp_rdat});
    @(posedge clk);
    #1;
    // Garbage on the request bus after acceptance must be ignored.
    req_val  = 1'b0;
    req_we   = 1'($urandom_range(0, 1));
    req_byte = 1'($urandom_range(0, 1));
    req_adr  = $urandom;
    req_wdat = $urandom;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (resp_val) break;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    expv = exp_q.pop_front();
    chk({tag, "_rdat"}, resp_rdat, expv[31:0]);
    chk({tag, "_err"}, 32'(resp_err), 32'(expv[32]));
    chk({tag, "_busy_cnt_resp"}, 32'(busy_cnt), 32'(16'(exp_busy + 16'(LAT))));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_stall_val"}, 32'(resp_val), 32'd1);
      chk({tag, "_stall_rdat"}, resp_rdat, expv[31:0]);
      chk({tag, "_stall_err"}, 32'(resp_err), 32'(expv[32]));
      chk({tag, "_stall_req_rdy"}, 32'(req_rdy), 32'd0);
      chk({tag, "_stall_busy_cnt"}, 32'(busy_cnt), 32'(16'(exp_busy + 16'(LAT + s + 1))));
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    resp_rdy = 1'b0;
    exp_acc  = exp_acc + 16'd1;
    exp_busy = 16'(exp_busy + 16'(LAT + 1 + stall));
    @(negedge clk);
    chk({tag, "_val_low"}, 32'(resp_val), 32'd0);
    chk({tag, "_acc_cnt"}, 32'(acc_cnt), 32'(exp_acc));
    chk({tag, "_busy_cnt"}, 32'(busy_cnt), 32'(exp_busy));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  ln;
    flush    = 1'b0;
    req_val  = 1'b0;
    req_we   = 1'b0;
    req_byte = 1'b0;
    req_adr  = 32'd0;
    req_wdat = 32'd0;
    resp_rdy = 1'b0;

    // Reset and idle state
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("rst_resp_val", 32'(resp_val), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
    chk("rst_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("rst_rdat", resp_rdat, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // Word store then load
    transact(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 0, "st_word");
    transact(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 0, "ld_word");
    chk("acc_cnt_two", 32'(acc_cnt), 32'd2);

    // Byte lanes; upper store bits must not leak into the lane
    transact(1'b1, 1'b0, 32'h20, 32'h11223344, 32'd0, 1'b0, 0, "st_word20");
    transact(1'b1, 1'b1, 32'h22, 32'hFFFFFFAB, 32'd0, 1'b0, 1, "st_byte22");
    transact(1'b0, 1'b0, 32'h20, 32'd0, 32'h11AB3344, 1'b0, 0, "ld_word20");
    transact(1'b0, 1'b1, 32'h23, 32'd0, 32'h00000011, 1'b0, 0, "ld_byte23");
    transact(1'b0, 1'b1, 32'h20, 32'd0, 32'h00000044, 1'b0, 0, "ld_byte20");

    // Out of range: errored store writes nothing, errored load reads 0
    transact(1'b1, 1'b0, 32'h00, 32'h0BADF00D, 32'd0, 1'b0, 0, "st_word00");
    transact(1'b1, 1'b0, 32'h100, 32'hFFFFFFFF, 32'd0, 1'b1, 0, "st_oor");
    transact(1'b0, 1'b0, 32'h00, 32'd0, 32'h0BADF00D, 1'b0, 0, "ld_after_oor");
    transact(1'b0, 1'b0, 32'h8000_0010, 32'd0, 32'd0, 1'b1, 0, "ld_oor");

    // Backpressure in RESP
    transact(1'b0, 1'b0, 32'h20, 32'd0, 32'h11AB3344, 1'b0, 5, "bp_load");

    // Randomised word/byte traffic in an otherwise unused region
    for (int i = 0; i < 6; i++) begin
      a  = 32'h40 + 32'(4 * $urandom_range(0, 15));
      d  = $urandom;
      ln = 2'($urandom_range(0, 3));
      transact(1'b1, 1'b0, a, d, 32'd0, 1'b0, $urandom_range(0, 2), "rnd_st");
      transact(1'b0, 1'b0, a | 32'(ln), 32'd0, d, 1'b0, $urandom_range(0, 2), "rnd_ld");
      transact(1'b0, 1'b1, a | 32'(ln), 32'd0, (d >> (8 * ln)) & 32'hFF, 1'b0, 0, "rnd_ldb");
    end

    // Reset during ACCESS of a store aborts it
    transact(1'b1, 1'b0, 32'h30, 32'h00000055, 32'd0, 1'b0, 0, "st_word30");
    @(negedge clk);
    for (int n = 0; n < 20 && !req_rdy; n++) @(negedge clk);
    req_val  = 1'b1;
    req_we   = 1'b1;
    req_byte = 1'b0;
    req_adr  = 32'h30;
    req_wdat = 32'h99999999;
    @(posedge clk);
    #1;
    req_val = 1'b0;
    @(negedge clk);
    chk("abort_in_access", 32'(dbg_state), 32'(ACCESS));
    flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b1;
    exp_acc  = 16'd0;
    exp_busy = 16'd0;
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_acc_cnt", 32'(acc_cnt), 32'd0);
    chk("abort_busy_cnt", 32'(busy_cnt), 32'd0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_resp_val", 32'(resp_val), 32'd0);
    end
    transact(1'b0, 1'b0, 32'h30, 32'd0, 32'h00000055, 1'b0, 0, "ld_after_abort");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Multi-cycle data-memory responder: the far end of the memory-stage data access (address, write data, write enable, byte flag in; read data out).
- Replaces the single-cycle combinational data RAM with a request/response handshake of configurable latency, byte-lane stores/loads, out-of-range error and a busy signal that feeds the pipeline stall.
- Sits between the memory stage (initiator) and on-chip data RAM.

Parameters:
- ADR_W, 6, word-address bits; RAM depth = 2**ADR_W words of 32 bits.
- LAT, 2, access latency in cycles from request acceptance to resp_val (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- flush  in  1  reset, synchronous, active-low (flush==0 at a rising edge resets).
- req_val  in  1  request valid.
- req_rdy  out  1  responder can accept; a request transfers on req_val&&req_rdy.
- req_we  in  1  1=store, 0=load.
- req_byte  in  1  1=byte access (lane req_adr[1:0]), 0=word access.
- req_adr  in  32  byte address.
- req_wdat  in  32  store data; byte store uses bits [7:0].
- resp_val  out  1  response valid.
- resp_rdy  in  1  initiator accepts response; transfers on resp_val&&resp_rdy.
- resp_rdat  out  32  load data; 0 for stores and errors.
- resp_err  out  1  address out of range; qualified by resp_val.
- busy  out  1  state!=IDLE; stall source for the pipeline.
- acc_cnt  out  16  completed response handshakes, wraps at 16'hFFFF->0.
- busy_cnt  out  16  cycles with busy=1, wraps.

Behaviour:
- Reset (flush==0): state=IDLE, req_rdy=1 after reset, resp_val=0, resp_rdat=0, resp_err=0, busy=0, acc_cnt=0, busy_cnt=0, latency counter=0. RAM contents not cleared.
- Reset mid-operation aborts the request; a store not yet committed never writes RAM.
- States: IDLE, ACCESS, RESP.
- IDLE: req_rdy=1. On req_val, capture we/byte/adr/wdat, load cnt=LAT-1, go ACCESS.
- ACCESS: req_rdy=0. If cnt!=0, decrement. If cnt==0, perform the access at this edge and go RESP.
  - Commit: latch resp_rdat and resp_err.
  - Store: update RAM.
- Resulting latency: request accepted at edge E, resp_val high from edge E+LAT.
- RESP: resp_val=1 with resp_rdat/resp_err held stable until resp_rdy=1. At that edge: acc_cnt+1, go IDLE, resp_val=0.
  - No same-cycle re-accept; minimum spacing LAT+1 cycles per access.
- Range check: error when req_adr[31:ADR_W+2]!=0. Errored store writes nothing; errored load returns 0.
- Word load: RAM[adr[ADR_W+1:2]]. adr[1:0] ignored.
- Byte load: lane adr[1:0] of the word, zero-extended.
- Word store: writes all 32 bits.
- Byte store: writes req_wdat[7:0] into lane adr[1:0] only; other lanes unchanged.
- Store response: resp_rdat=0.
- busy = (state!=IDLE), registered-state decode, no combinational path from req_val.
- busy_cnt increments on every cycle with busy=1.
- Both counters wrap silently.
- req_val low in IDLE: no state change.
- Changes on req_* while not in IDLE are ignored.

Decomposition:
- Shared package holds:
  - state enum (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - lane-select/zero-extend constant BYTE_MASK=32'hFF
  - counter width CNT_W=16
- One natural sub-module: dmem_bram, a synchronous RAM with 4 byte-enable write lanes and a combinational read, depth 2**ADR_W.
- FSM, range check, lane muxing and counters live in dmem_resp.

Test Plan:
- Reset/idle: flush=0 for 2 cycles, then 1 -> req_rdy=1, resp_val=0, busy=0, acc_cnt=0, busy_cnt=0.
- Word store then load, LAT=2: store adr=0x10, wdat=0xDEADBEEF; then load adr=0x10.
  - resp_val rises exactly 2 edges after each accept.
  - load resp_rdat=0xDEADBEEF, resp_err=0, acc_cnt=2.
- Byte ops: word 0x11223344 at adr 0x20; byte store 0xAB to adr 0x22.
  - word load returns 0x11AB3344.
  - byte load adr 0x23 returns 0x00000011.
- Out of range, ADR_W=6: store adr=0x100, wdat=0xFFFFFFFF.
  - resp_err=1, resp_rdat=0.
  - load adr 0x00 returns its prior value, unchanged.
- Backpressure: resp_rdy=0 for 5 cycles in RESP.
  - resp_val, resp_rdat and resp_err stay stable; req_rdy=0; busy_cnt increments each cycle.
  - completes the cycle resp_rdy=1; acc_cnt increments once.
- Abort: flush=0 during ACCESS of a store to adr 0x30 whose old value is 0x55.
  - RAM[0x30] stays 0x55; resp_val never asserts; state returns to IDLE.
